shift_seq: RTL and testbench
============================

# shift_seq

Command sequencer sitting directly upstream of the 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake: load a word, shift right or left N times with a fill bit, or rotate right N times. It then drives the register's mode bits (s1,s0), serial inputs (in, in_left) and parallel data (r_in) cycle by cycle, and pulses done when finished. The register's contents are fed back so the sequencer can rotate.

## Interface
Parameters:
- WIDTH, 4, register width; r_in and r_q are WIDTH bits.
- CNT_W, 3, width of the shift count; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset, synchronous, active-low; takes effect on the rising edge where clr==0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  opcode: 00 LOAD, 01 SHR, 10 SHL, 11 ROR.
- cmd_count  in  CNT_W  number of shift/rotate steps; ignored for LOAD.
- cmd_fill  in  1  serial fill bit for SHR/SHL.
- cmd_data  in  WIDTH  word for LOAD.
- r_q  in  WIDTH  current register contents (feedback).
- s1, s0  out  1 each  register mode: 00 hold, 01 shift right, 10 shift left, 11 load.
- in  out  1  register right-shift serial input (enters at MSB).
- in_left  out  1  register left-shift serial input (enters at LSB).
- r_in  out  WIDTH  register parallel load data.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at command completion.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cmd_ready=1, {s1,s0}=00. On an edge with cmd_valid&cmd_ready, latch op/count/fill/data.
  - If op≠LOAD and count==0: next state is DONE.
  - Otherwise: next state is RUN, with the step counter set to count (LOAD uses 1).
- RUN: outputs decoded from the latched op. Each edge in RUN is one register step and decrements the counter; after the final step (counter==1), next state is DONE.
  - LOAD: {s1,s0}=11, r_in=latched data.
  - SHR: 01, in=fill.
  - SHL: 10, in_left=fill.
  - ROR: 01, in=r_q[0]. This is a live combinational feedback, so each step rotates the current contents.
- DONE: {s1,s0}=00, done=1 for exactly one cycle, then IDLE.
- Outputs not used by the current op are driven to 0: in, in_left, r_in.
- cmd_* inputs are ignored outside IDLE, and latched values stay stable through RUN.
- No abort: the only way to stop a command is clr.

## Timing
- Reset (clr==0 at an edge): state=IDLE, counter=0, latched fields=0. Resulting outputs: s1=s0=0, in=in_left=0, r_in=0, busy=0, done=0, cmd_ready=1.
- Reset mid-RUN: the sequencer goes to IDLE at that edge with no done pulse. The register holds from the next cycle (mode 00).
- Accept at edge k: RUN is visible after k. The register steps at edges k+1 … k+N. DONE/done is visible after k+N, and cmd_ready=1 again after k+N+1.
- Count==0 (non-LOAD): DONE after k, cmd_ready after k+1; the register never leaves hold.
- Throughput: a command of N steps occupies N+2 cycles from accept to the next possible accept.
- All outputs are Moore (state-decoded) except in during ROR, which follows r_q combinationally.
- The counter is CNT_W bits and never wraps: it is loaded only in IDLE and decremented only while ≥1.

## Structure
- Package shift_seq_pkg holds:
  - Opcode constants OP_LOAD/OP_SHR/OP_SHL/OP_ROR.
  - Mode constants MODE_HOLD=00, MODE_SHR=01, MODE_SHL=10, MODE_LOAD=11.
  - State typedef {IDLE, RUN, DONE}.
- One sub-module, shift_seq_cnt: a CNT_W-bit loadable down-counter with load, dec and last (count==1) outputs. The FSM, command latch and output decode live in shift_seq.
- Bench instantiates shift_seq driving the shift register, r fed back to r_q.

## Test plan
- Reset then LOAD 4'b1011: one cycle of mode 11 with r_in=1011; register=1011; done pulses once; cmd_ready returns after 3 cycles total.
- From 1011, SHR count=2 fill=0: two cycles of mode 01, in=0; register 0101 then 0010; done after the second step.
- From 0010, SHL count=3 fill=1: mode 10 ×3, in_left=1; register 0101, 1011, 0111.
- From 1001, ROR count=4: mode 01 ×4 with in=r_q[0]; register 1100, 0110, 0011, 1001 (back to start).
- SHR count=0: no mode other than 00 is ever driven; done after 1 cycle; register unchanged.
- clr=0 during step 2 of SHL count=5: next cycle mode=00, busy=0, done never pulses, cmd_ready=1; cmd_valid during RUN is ignored (cmd_ready=0 throughout).

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared opcodes, register mode encodings and FSM state type for the
// command sequencer that drives the 4-bit universal shift register.
package shift_seq_pkg;

    // Command opcodes as presented on cmd_op
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    // Register mode encodings driven on {s1,s0}
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter holding the number of register steps left in the
// current command. It saturates at zero and flags the final step.
module shift_seq_cnt
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count register; clr is active-low and synchronous
    always_ff @(posedge clk_i) begin
        if (!clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Load has priority; decrement only while non-zero so the count never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_seq.sv
// Command sequencer for the universal shift register. Accepts one command
// in IDLE, drives mode/serial/parallel lines for each step in RUN, then
// pulses done for one cycle in DONE. ROR feeds r_q[0] back into the MSB.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] r_q,
    output logic             s1,
    output logic             s0,
    output logic             in,
    output logic             in_left,
    output logic [WIDTH-1:0] r_in,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic             fill_q;
    logic             fill_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    logic             cntLoad;
    logic             cntDec;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntLast;
    logic [1:0]       mode;
    logic             unusedRq;

    // Only the LSB of the register is needed, for the rotate feedback
    assign unusedRq = ^r_q[WIDTH-1:1];

    shift_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i      (clk),
        .clr_i      (clr),
        .load_i     (cntLoad),
        .dec_i      (cntDec),
        .load_val_i (cntLoadVal),
        .last_o     (cntLast)
    );

    // State and command latch; clearing drops any command in flight
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            op_q    <= OP_LOAD;
            fill_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
        end
    end

    // Next-state, command capture and Moore output decode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fill_d     = fill_q;
        data_d     = data_q;
        cntLoad    = 1'b0;
        cntDec     = 1'b0;
        cntLoadVal = cmd_count;
        mode       = MODE_HOLD;
        in         = 1'b0;
        in_left    = 1'b0;
        r_in       = '0;
        busy       = 1'b0;
        done       = 1'b0;
        cmd_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    fill_d  = cmd_fill;
                    data_d  = cmd_data;
                    cntLoad = 1'b1;
                    if (cmd_op == OP_LOAD) begin
                        cntLoadVal = CNT_W'(1);
                        state_d    = RUN;
                    end else if (cmd_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                busy   = 1'b1;
                cntDec = 1'b1;
                case (op_q)
                    OP_LOAD: begin
                        mode = MODE_LOAD;
                        r_in = data_q;
                    end
                    OP_SHR: begin
                        mode = MODE_SHR;
                        in   = fill_q;
                    end
                    OP_SHL: begin
                        mode    = MODE_SHL;
                        in_left = fill_q;
                    end
                    default: begin
                        mode = MODE_SHR;
                        in   = r_q[0];
                    end
                endcase
                if (cntLast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s1 = mode[1];
    assign s0 = mode[0];

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: a behavioural 4-bit universal shift register is
// wired to the sequencer, commands are queued with their expected outcome,
// and a negedge monitor checks every step and every done pulse.
module tb_shift_seq;
    import shift_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;
    logic             s1;
    logic             s0;
    logic             in;
    logic             in_left;
    logic [WIDTH-1:0] r_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] regQ = '0;

    typedef struct {
        logic [1:0]       op;
        logic             fill;
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] expReg;
        int               expSteps;
    } exp_t;

    exp_t sbQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   stepCount = 0;

    always #5 clk = ~clk;

    shift_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_fill  (cmd_fill),
        .cmd_data  (cmd_data),
        .r_q       (regQ),
        .s1        (s1),
        .s0        (s0),
        .in        (in),
        .in_left   (in_left),
        .r_in      (r_in),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural universal shift register driven by the sequencer
    always @(posedge clk) begin
        case ({s1, s0})
            2'b01:   regQ <= {in, regQ[WIDTH-1:1]};
            2'b10:   regQ <= {regQ[WIDTH-2:0], in_left};
            2'b11:   regQ <= r_in;
            default: regQ <= regQ;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: checks each active step against the head command, and pops on done
    initial begin
        forever begin
            @(negedge clk);
            if ((s1 | s0) === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_step", {30'd0, s1, s0}, 32'(MODE_HOLD));
                end else begin
                    logic [1:0] expMode;
                    logic       expIn;
                    logic       expInLeft;
                    logic [3:0] expRin;
                    exp_t       head;
                    head      = sbQ[0];
                    expIn     = 1'b0;
                    expInLeft = 1'b0;
                    expRin    = 4'b0000;
                    case (head.op)
                        OP_LOAD: begin expMode = 2'b11; expRin = head.data; end
                        OP_SHR:  begin expMode = 2'b01; expIn = head.fill; end
                        OP_SHL:  begin expMode = 2'b10; expInLeft = head.fill; end
                        default: begin expMode = 2'b01; expIn = regQ[0]; end
                    endcase
                    stepCount++;
                    checkOutput("step_mode", {30'd0, s1, s0}, {30'd0, expMode});
                    checkOutput("step_in", {31'd0, in}, {31'd0, expIn});
                    checkOutput("step_in_left", {31'd0, in_left}, {31'd0, expInLeft});
                    checkOutput("step_r_in", {28'd0, r_in}, {28'd0, expRin});
                    checkOutput("step_busy", {31'd0, busy}, 32'd1);
                end
            end
            if (done === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t item;
                    item = sbQ.pop_front();
                    checkOutput("done_steps", stepCount, item.expSteps);
                    checkOutput("done_reg", {28'd0, regQ}, {28'd0, item.expReg});
                    checkOutput("done_mode_hold", {30'd0, s1, s0}, 32'd0);
                end
                stepCount = 0;
            end
        end
    end

    // Issues one command and checks handshake timing; expEdges counts edges after accept until ready
    task automatic applyStimulus(input logic [1:0] op, input logic [CNT_W-1:0] count,
                                 input logic fill, input logic [WIDTH-1:0] data,
                                 input logic [WIDTH-1:0] expReg, input int expSteps,
                                 input int expEdges);
        exp_t item;
        int   edges;
        @(negedge clk);
        checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        item.op       = op;
        item.fill     = fill;
        item.data     = data;
        item.expReg   = expReg;
        item.expSteps = expSteps;
        sbQ.push_back(item);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = count;
        cmd_fill  = fill;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_count = ~count;
        cmd_fill  = ~fill;
        cmd_data  = ~data;
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        checkOutput("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!cmd_ready && edges < 40);
        checkOutput("ready_latency", edges, expEdges);
        checkOutput("sb_drained", sbQ.size(), 0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t abortItem;
        clr       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        cmd_fill  = 1'b0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mode", {30'd0, s1, s0}, 32'd0);
        checkOutput("rst_in", {31'd0, in}, 32'd0);
        checkOutput("rst_in_left", {31'd0, in_left}, 32'd0);
        checkOutput("rst_r_in", {28'd0, r_in}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
        clr = 1'b1;

        applyStimulus(OP_LOAD, 3'd0, 1'b0, 4'b1011, 4'b1011, 1, 2);
        applyStimulus(OP_SHR,  3'd2, 1'b0, 4'b1111, 4'b0010, 2, 3);
        applyStimulus(OP_SHL,  3'd3, 1'b1, 4'b0000, 4'b0111, 3, 4);
        applyStimulus(OP_LOAD, 3'd5, 1'b1, 4'b1001, 4'b1001, 1, 2);
        applyStimulus(OP_ROR,  3'd4, 1'b1, 4'b0110, 4'b1001, 4, 5);
        applyStimulus(OP_SHR,  3'd0, 1'b1, 4'b1111, 4'b1001, 0, 1);
        applyStimulus(OP_ROR,  3'd0, 1'b0, 4'b0000, 4'b1001, 0, 1);
        applyStimulus(OP_SHL,  3'd7, 1'b0, 4'b1111, 4'b0000, 7, 8);
        applyStimulus(OP_LOAD, 3'd0, 1'b0, 4'b0110, 4'b0110, 1, 2);
        applyStimulus(OP_ROR,  3'd7, 1'b0, 4'b0000, 4'b1100, 7, 8);

        // SHL count=5 cleared during step 2, with a stray command held valid during RUN
        @(negedge clk);
        abortItem.op       = OP_SHL;
        abortItem.fill     = 1'b1;
        abortItem.data     = 4'b0000;
        abortItem.expReg   = 4'b0000;
        abortItem.expSteps = -1;
        sbQ.push_back(abortItem);
        cmd_valid = 1'b1;
        cmd_op    = OP_SHL;
        cmd_count = 3'd5;
        cmd_fill  = 1'b1;
        cmd_data  = 4'b0000;
        @(posedge clk);
        #1;
        cmd_op   = OP_LOAD;
        cmd_data = 4'b1111;
        checkOutput("abort_ready_step1", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abort_ready_step2", {31'd0, cmd_ready}, 32'd0);
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        checkOutput("abort_mode", {30'd0, s1, s0}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_no_done", sbQ.size(), 1);
        checkOutput("abort_steps", stepCount, 2);
        checkOutput("abort_reg", {28'd0, regQ}, {28'd0, 4'b0011});
        sbQ.delete();
        stepCount = 0;

        applyStimulus(OP_LOAD, 3'd0, 1'b0, 4'b0101, 4'b0101, 1, 2);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
